// File: rtl/prm_pkg.sv
// Shared definitions for the PRM obstacle scanner.
//   DEF_N_EDGE / DEF_CODE_W / DEF_CNT_W : parameter defaults
//   scan_state_e                        : scanner FSM states
//   code_fld_e                          : bit index of each obstacle code field (A = LSB)
package prm_pkg;

  localparam int DEF_N_EDGE = 2048;
  localparam int DEF_CODE_W = 15;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  typedef enum logic [3:0] {
    FLD_A = 4'd0,  FLD_B = 4'd1,  FLD_C = 4'd2,  FLD_D = 4'd3,
    FLD_E = 4'd4,  FLD_F = 4'd5,  FLD_G = 4'd6,  FLD_H = 4'd7,
    FLD_I = 4'd8,  FLD_J = 4'd9,  FLD_K = 4'd10, FLD_L = 4'd11,
    FLD_M = 4'd12, FLD_N = 4'd13, FLD_O = 4'd14
  } code_fld_e;

endpackage

// File: rtl/prm_sat_counter.sv
// Saturating up-counter for the per-frame obstacle count.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : restart the count; with inc_i the restarted value is 1
//   inc_i      : count one event, holding at all-ones
//   cnt_o      : current count
module prm_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? ONE : '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/prm_obstacle_scanner.sv
// Streams obstacle codes to the external edge-checker bank and ORs the
// returned per-edge hit masks into a blocked-edge bitmap, then hands the
// bitmap and obstacle count to the planner over valid/ready.
//   obs_valid/obs_ready/obs_code/obs_last : obstacle code stream in
//   chk_code / chk_mask                   : code to the bank, hit mask back
//   res_valid/res_ready/res_blocked/res_count : frame result out
//   busy                                  : frame in progress (SCAN/DRAIN)
//
// state | meaning
// IDLE  | waiting for the first code of a frame
// SCAN  | accepting codes, one per cycle
// DRAIN | absorbing the mask of the last code
// DONE  | result held until the planner takes it
module prm_obstacle_scanner
  import prm_pkg::*;
#(
  parameter int N_EDGE = DEF_N_EDGE,
  parameter int CODE_W = DEF_CODE_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              obs_valid,
  output logic              obs_ready,
  input  logic [CODE_W-1:0] obs_code,
  input  logic              obs_last,
  output logic [CODE_W-1:0] chk_code,
  input  logic [N_EDGE-1:0] chk_mask,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N_EDGE-1:0] res_blocked,
  output logic [CNT_W-1:0]  res_count,
  output logic              busy
);

  scan_state_e       state_q, state_d;
  logic [CODE_W-1:0] chk_code_q, chk_code_d;
  logic              chk_vld_q;
  logic [N_EDGE-1:0] acc_q, acc_d;
  logic              res_valid_q, res_valid_d;
  logic              ready_st;
  logic              frame_start;
  logic              accept;

  always_comb begin
    state_d     = state_q;
    ready_st    = 1'b0;
    frame_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready_st = 1'b1;
        if (obs_valid) begin
          frame_start = 1'b1;
          state_d     = obs_last ? ST_DRAIN : ST_SCAN;
        end
      end
      ST_SCAN: begin
        ready_st = 1'b1;
        if (obs_valid && obs_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        if (res_valid_q && res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is forced low while reset is held so nothing upstream sees a
  // handshake before the block is live.
  assign obs_ready = ready_st & rst_n;
  assign accept    = obs_valid & obs_ready;

  assign chk_code_d = accept ? obs_code : chk_code_q;

  // Only the cycle after an accept carries a mask that belongs to a real
  // code; every other cycle the bank output is stale and must not be ORed.
  always_comb begin
    acc_d = acc_q;
    if (frame_start)    acc_d = '0;
    else if (chk_vld_q) acc_d = acc_q | chk_mask;
  end

  // Registered valid: it rises one edge after entering DONE, once the final
  // mask has settled into the accumulator, and drops on the handshake edge.
  assign res_valid_d = (state_q == ST_DONE) && !(res_valid_q && res_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      chk_code_q  <= '0;
      chk_vld_q   <= 1'b0;
      acc_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      chk_code_q  <= chk_code_d;
      chk_vld_q   <= accept;
      acc_q       <= acc_d;
      res_valid_q <= res_valid_d;
    end
  end

  prm_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (frame_start),
    .inc_i (accept),
    .cnt_o (res_count)
  );

  assign chk_code    = chk_code_q;
  assign res_valid   = res_valid_q;
  assign res_blocked = acc_q;
  assign busy        = (state_q == ST_SCAN) || (state_q == ST_DRAIN);

endmodule
